riscv_cbm: RTL and testbench
============================

RISCV_CBM -- requirements
Module: riscv_cbm

Interface
REQ-001 clk_i  input  1  core clock; all state updates on its rising edge.
REQ-002 rst_i  input  1  reset, asynchronous and active-high.
REQ-003 opcode_valid_i  input  1  issue stage presents a CBM multiply this cycle.
REQ-004 opcode_ra_operand_i  input  32  multiplicand (rs1 value).
REQ-005 opcode_rb_operand_i  input  32  multiplier / column mask (rs2 value).
REQ-006 opcode_rd_idx_i  input  5  destination register index.
REQ-007 flush_i  input  1  pipeline flush; aborts any in-flight operation.
REQ-008 opcode_accept_o  output  1  operation accepted this cycle.
REQ-009 busy_o  output  1  unit occupied; issue stage stalls dependent CBM ops.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 writeback_valid_o  output  1  result valid for register writeback.
REQ-012 writeback_rd_idx_o  output  5  destination index of the result.
REQ-013 writeback_value_o  output  32  low 32 bits of the unsigned product.

Function
REQ-014 The state register state_q SHALL be 2 bits, encoded IDLE=0, RUN=1, DONE=2; encoding 3 SHALL return to IDLE on the next edge.
REQ-015 opcode_accept_o SHALL equal opcode_valid_i AND state_q==IDLE AND NOT flush_i (combinational).
REQ-016 On accept: multiplicand_q = {32'b0, ra}; column_mask_q = rb; accumulator_q = 64'b0; rd_idx_q = rd_idx; state_q -> RUN.
REQ-017 Each RUN cycle with column_mask_q != 0: if column_mask_q[0], accumulator_q += multiplicand_q (64-bit, wrap mod 2^64); then multiplicand_q <<= 1 and column_mask_q >>= 1.
REQ-018 A zero column SHALL add nothing; accumulator_q is updated only on a set column (column bypass).
REQ-019 The RUN exit condition SHALL be selected per REQ-031; on exit, state_q -> DONE.
REQ-020 In DONE for exactly one cycle: done_o=1, writeback_valid_o=1, writeback_rd_idx_o=rd_idx_q, writeback_value_o=accumulator_q[31:0]; next state IDLE.
REQ-021 Outside DONE, writeback_valid_o and done_o SHALL be 0, and writeback_value_o and writeback_rd_idx_o SHALL be 0.
REQ-022 busy_o SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-023 opcode_valid_i asserted while not IDLE SHALL be ignored (no accept, no state change).
REQ-024 flush_i in RUN or DONE SHALL force state_q to IDLE on the next edge, with no writeback that cycle if in DONE (writeback_valid_o gated by NOT flush_i).
REQ-025 When flush_i and opcode_valid_i coincide in IDLE, flush SHALL win and the operation SHALL not be accepted.
REQ-026 The operation SHALL be unsigned; the upper 32 product bits are kept internally and not output.

Reset
REQ-027 While rst_i=1 the unit SHALL asynchronously clear: state_q=IDLE, multiplicand_q=0, column_mask_q=0, accumulator_q=0, rd_idx_q=0, iteration counter=0.
REQ-028 Reset SHALL drive outputs to: opcode_accept_o=0, busy_o=0, done_o=0, writeback_valid_o=0, writeback_rd_idx_o=0, writeback_value_o=0.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no writeback.
REQ-030 The first accept SHALL be possible in the first cycle after rst_i deasserts.

Configuration
REQ-031 With CBM_EARLY_EXIT_EN defined, RUN SHALL exit when column_mask_q==0 at the start of a RUN cycle, giving writeback 2 cycles after the accept cycle for rb=0 and m+3 cycles for rb!=0 (m = index of the most significant set bit of rb).
REQ-032 With CBM_EARLY_EXIT_EN undefined, a 6-bit iteration counter (cleared on accept) SHALL run exactly 32 RUN iterations and then go to DONE, giving writeback exactly 33 cycles after accept for any rb.

Verification (CBM_EARLY_EXIT_EN defined unless stated)
REQ-033 ra=7, rb=6, rd=12 -> writeback_valid_o 5 cycles after accept, value 42, rd_idx 12, done_o a one-cycle pulse.
REQ-034 ra=0xFFFFFFFF, rb=0xFFFFFFFF -> value 0x00000001 after 34 cycles; macro undefined, same result after 33 cycles; ra=123, rb=0 -> value 0 after 2 cycles.
REQ-035 Second opcode_valid_i during RUN -> opcode_accept_o=0, first result unaffected, second accepted only once state_q is back in IDLE.
REQ-036 flush_i in the 3rd RUN cycle of ra=5, rb=0x80000000 -> no writeback, busy_o=0 next cycle, new op accepted the following cycle.
REQ-037 rst_i pulsed mid-RUN -> all outputs 0 immediately, no writeback; then ra=3, rb=3 -> value 9.

Source files
------------

// File: rtl/riscv_cbm.sv
// Column-bypass unsigned 32x32 multiplier: it writes back the low 32 bits of the product.
// Define CBM_EARLY_EXIT_EN to leave RUN once no multiplier columns remain; without it, RUN always lasts 32 cycles.
module riscv_cbm (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic        flush_i,
    output logic        opcode_accept_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        writeback_valid_o,
    output logic [4:0]  writeback_rd_idx_o,
    output logic [31:0] writeback_value_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_s;
    logic [63:0] multiplicand_q;
    logic [63:0] accumulator_q;
    logic [31:0] column_mask_q;
    logic [4:0]  rd_idx_q;
    logic        accept_s;
    logic        run_exit_s;
`ifndef CBM_EARLY_EXIT_EN
    logic [5:0]  iter_q;
`endif

    // Issue handshake; a flush or a held reset blocks acceptance.
    always_comb begin
        accept_s = opcode_valid_i && (state_q == IDLE) && !flush_i && !rst_i;
    end

    // RUN exit decision for the configured build.
    always_comb begin
`ifdef CBM_EARLY_EXIT_EN
        run_exit_s = (column_mask_q == 32'd0);
`else
        run_exit_s = (iter_q == 6'd31);
`endif
    end

    // Next-state logic; the unused encoding recovers to IDLE.
    always_comb begin
        state_s = IDLE;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_s = IDLE;
                end else if (run_exit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_s;
        end
    end

    // Shift-and-add datapath; a clear column leaves the accumulator untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            multiplicand_q <= 64'd0;
            column_mask_q  <= 32'd0;
            accumulator_q  <= 64'd0;
            rd_idx_q       <= 5'd0;
        end else if (accept_s) begin
            multiplicand_q <= {32'd0, opcode_ra_operand_i};
            column_mask_q  <= opcode_rb_operand_i;
            accumulator_q  <= 64'd0;
            rd_idx_q       <= opcode_rd_idx_i;
        end else if ((state_q == RUN) && (column_mask_q != 32'd0)) begin
            if (column_mask_q[0]) begin
                accumulator_q <= accumulator_q + multiplicand_q;
            end else begin
                accumulator_q <= accumulator_q;
            end
            multiplicand_q <= multiplicand_q << 1;
            column_mask_q  <= column_mask_q >> 1;
        end else begin
            multiplicand_q <= multiplicand_q;
            column_mask_q  <= column_mask_q;
            accumulator_q  <= accumulator_q;
            rd_idx_q       <= rd_idx_q;
        end
    end

`ifndef CBM_EARLY_EXIT_EN
    // Fixed-length iteration counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iter_q <= 6'd0;
        end else if (accept_s) begin
            iter_q <= 6'd0;
        end else if (state_q == RUN) begin
            iter_q <= iter_q + 6'd1;
        end else begin
            iter_q <= iter_q;
        end
    end
`endif

    // Result presentation; a flush in DONE suppresses the writeback.
    always_comb begin
        opcode_accept_o    = accept_s;
        busy_o             = (state_q == RUN) || (state_q == DONE);
        done_o             = 1'b0;
        writeback_valid_o  = 1'b0;
        writeback_rd_idx_o = 5'd0;
        writeback_value_o  = 32'd0;
        if (state_q == DONE) begin
            done_o             = 1'b1;
            writeback_valid_o  = !flush_i;
            writeback_rd_idx_o = rd_idx_q;
            writeback_value_o  = accumulator_q[31:0];
        end else begin
            done_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_cbm.sv
// Self-checking bench for riscv_cbm: table vectors, random operands and corner sequences.
module tb_riscv_cbm;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        opcode_valid_i = 1'b0;
    logic [31:0] opcode_ra_operand_i = 32'd0;
    logic [31:0] opcode_rb_operand_i = 32'd0;
    logic [4:0]  opcode_rd_idx_i = 5'd0;
    logic        flush_i = 1'b0;
    logic        opcode_accept_o;
    logic        busy_o;
    logic        done_o;
    logic        writeback_valid_o;
    logic [4:0]  writeback_rd_idx_o;
    logic [31:0] writeback_value_o;

    int checks = 0;
    int errors = 0;

    riscv_cbm dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .opcode_valid_i      (opcode_valid_i),
        .opcode_ra_operand_i (opcode_ra_operand_i),
        .opcode_rb_operand_i (opcode_rb_operand_i),
        .opcode_rd_idx_i     (opcode_rd_idx_i),
        .flush_i             (flush_i),
        .opcode_accept_o     (opcode_accept_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .writeback_valid_o   (writeback_valid_o),
        .writeback_rd_idx_o  (writeback_rd_idx_o),
        .writeback_value_o   (writeback_value_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rd;
        logic [31:0] val;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference latency (cycles from accept to writeback) from the exit rule.
    function automatic int ref_latency(input logic [31:0] rb);
`ifdef CBM_EARLY_EXIT_EN
        int m;
        if (rb == 32'd0) return 2;
        m = 0;
        for (int i = 0; i < 32; i++) if (rb[i]) m = i;
        return m + 3;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    // Called right after a negedge; returns at the negedge of the first cycle after accept.
    task automatic issue(input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd);
        opcode_valid_i      = 1'b1;
        opcode_ra_operand_i = ra;
        opcode_rb_operand_i = rb;
        opcode_rd_idx_i     = rd;
        #1;
        chk("accept", {63'd0, opcode_accept_o}, 64'd1);
        @(posedge clk_i);
        #1 opcode_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    // Waits (bounded) for the writeback and checks timing, value and the return to IDLE.
    task automatic wait_result(input logic [31:0] rb, input logic [4:0] rd, input logic [31:0] val);
        int k;
        k = 1;
        while (!writeback_valid_o && k < 45) begin
            chk("quiet_outs", {26'd0, done_o, writeback_rd_idx_o, writeback_value_o}, 64'd0);
            chk("busy_run", {63'd0, busy_o}, 64'd1);
            @(negedge clk_i);
            k++;
        end
        chk("latency", 64'(k), 64'(ref_latency(rb)));
        chk("wb_value", {32'd0, writeback_value_o}, {32'd0, val});
        chk("wb_rd", {59'd0, writeback_rd_idx_o}, {59'd0, rd});
        chk("done_pulse", {62'd0, done_o, busy_o}, 64'd3);
        @(negedge clk_i);
        chk("after_done", {61'd0, done_o, writeback_valid_o, busy_o}, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd, input logic [31:0] val);
        issue(ra, rb, rd);
        wait_result(rb, rd, val);
    endtask

    initial begin
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{32'd7, 32'd6, 5'd12, 32'd42};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001};
        tbl[2] = '{32'd123, 32'd0, 5'd7, 32'd0};
        tbl[3] = '{32'd1, 32'h8000_0000, 5'd31, 32'h8000_0000};
        tbl[4] = '{32'h0001_0000, 32'h0001_0000, 5'd1, 32'd0};
        tbl[5] = '{32'h1234_5678, 32'd1, 5'd0, 32'h1234_5678};
        tbl[6] = '{32'd3, 32'd5, 5'd9, 32'd15};
        tbl[7] = '{32'd0, 32'h0000_FFFF, 5'd20, 32'd0};

        // Reset holds every output low even with a request pending.
        opcode_valid_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("reset_outs", {25'd0, opcode_accept_o, busy_o, done_o, writeback_valid_o,
                           writeback_rd_idx_o, writeback_value_o}, 64'd0);
        opcode_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        // First cycle after reset release accepts.
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].val);
        end

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, 5'($urandom_range(0, 31)), ref_product(ra, rb));
        end

        // Second request while busy is held off until IDLE.
        issue(32'd7, 32'd6, 5'd12);
        opcode_valid_i      = 1'b1;
        opcode_ra_operand_i = 32'd2;
        opcode_rb_operand_i = 32'd3;
        opcode_rd_idx_i     = 5'd4;
        #1;
        chk("no_accept_busy", {63'd0, opcode_accept_o}, 64'd0);
        wait_result(32'd6, 5'd12, 32'd42);
        #1;
        chk("accept_when_idle", {63'd0, opcode_accept_o}, 64'd1);
        @(posedge clk_i);
        #1 opcode_valid_i = 1'b0;
        @(negedge clk_i);
        wait_result(32'd3, 5'd4, 32'd6);

        // Flush in the third RUN cycle.
        issue(32'd5, 32'h8000_0000, 5'd3);
        @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        chk("flush_run_wbv", {63'd0, writeback_valid_o}, 64'd0);
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_run_busy", {62'd0, busy_o, writeback_valid_o}, 64'd0);
        run_op(32'd11, 32'd13, 5'd2, 32'd143);

        // Flush in DONE suppresses the writeback.
        issue(32'd9, 32'd2, 5'd5);
        lat = ref_latency(32'd2);
        for (int k = 1; k < lat; k++) @(negedge clk_i);
        chk("done_reached", {63'd0, done_o}, 64'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_done_wbv", {63'd0, writeback_valid_o}, 64'd0);
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_done_busy", {62'd0, busy_o, writeback_valid_o}, 64'd0);

        // Flush beats a request in IDLE.
        opcode_valid_i = 1'b1;
        flush_i        = 1'b1;
        #1;
        chk("flush_wins", {63'd0, opcode_accept_o}, 64'd0);
        @(posedge clk_i);
        #1;
        opcode_valid_i = 1'b0;
        flush_i        = 1'b0;
        @(negedge clk_i);
        chk("flush_wins_busy", {63'd0, busy_o}, 64'd0);

        // Reset mid-RUN discards the operation.
        issue(32'hFFFF, 32'hFFFF, 5'd8);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("midrun_reset_outs", {25'd0, opcode_accept_o, busy_o, done_o, writeback_valid_o,
                                  writeback_rd_idx_o, writeback_value_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op(32'd3, 32'd3, 5'd2, 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
